prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader_word_packer.sv | 36 +++
 rtl/prog_loader.sv | 116 +++++++++++
 tb/tb_prog_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader: FSM states and the
// field widths of the byte-stream header, instruction words and PC.
package prog_loader_pkg;

   localparam int MAX_WORDS_DEF = 256;
   localparam int HDR_W         = 16;
   localparam int WORD_W        = 32;
   localparam int ADDR_W        = 64;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Collects four bytes LSB-first into one instruction word. full is raised
// combinationally alongside the 4th byte so the owner can leave LOAD on
// that same edge; the packed word then stays stable until the next shift.
module word_packer
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              full
);

   logic [1:0] byte_cnt;

   assign full = shift && (byte_cnt == 2'd3);

   // Byte counter and shift register; new bytes enter at the top so the
   // first byte ends up in word[7:0].
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples pre-edge values regardless of process ordering.
         byte_cnt <= 2'd0;
         word     <= '0;
      end else if (clear) begin
         byte_cnt <= 2'd0;
      end else if (shift) begin
         byte_cnt <= byte_cnt + 2'd1;
         word     <= {byte_in, word[WORD_W-1:8]};
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a byte stream (16-bit LE word count,
// LE 32-bit words, XOR checksum byte), writes the words into instruction
// memory and releases the core from reset only on a clean checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error
);

   state_t            state;
   state_t            state_next;
   logic [HDR_W-1:0]  n_count;
   logic [HDR_W-1:0]  word_idx;
   logic [HDR_W-1:0]  word_idx_inc;
   logic [HDR_W-1:0]  n_hdr;
   logic [7:0]        checksum;
   logic [WORD_W-1:0] packed_word;
   logic              accept;
   logic              load_byte;
   logic              word_full;

   assign accept       = in_valid && in_ready;
   assign load_byte    = accept && (state == S_LOAD);
   assign word_idx_inc = word_idx + 16'd1;
   // Full count as it stands once the high header byte is taken.
   assign n_hdr        = {in_data, n_count[7:0]};

   word_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == S_WRITE),
      .shift   (load_byte),
      .byte_in (in_data),
      .word    (packed_word),
      .full    (word_full)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_HDR0;
      else       state <= state_next;
   end

   // Next-state decode; DONE and ERR are sticky until reset.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves it unassigned and no latch is inferred.
      state_next = state;
      case (state)
         S_HDR0:  if (accept) state_next = S_HDR1;
         S_HDR1:  if (accept) begin
                     if ({16'd0, n_hdr} > 32'(MAX_WORDS)) state_next = S_ERR;
                     else if (n_hdr == '0)                state_next = S_CHK;
                     else                                 state_next = S_LOAD;
                  end
         S_LOAD:  if (word_full) state_next = S_WRITE;
         S_WRITE: state_next = (word_idx_inc == n_count) ? S_CHK : S_LOAD;
         S_CHK:   if (accept) state_next = (in_data == checksum) ? S_DONE : S_ERR;
         S_DONE:  state_next = S_DONE;
         S_ERR:   state_next = S_ERR;
         default: state_next = S_ERR;
      endcase
   end

   // Output decode from the current state only.
   always_comb begin
      in_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      core_reset = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_HDR0, S_HDR1, S_LOAD, S_CHK: in_ready = 1'b1;
         S_WRITE: begin
            imem_we    = 1'b1;
            imem_addr  = {{(ADDR_W-HDR_W-2){1'b0}}, word_idx, 2'b00};
            imem_wdata = packed_word;
         end
         S_DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         S_ERR:   error = 1'b1;
         default: ;
      endcase
   end

   // Header count, word index and running checksum over word bytes only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_count  <= '0;
         word_idx <= '0;
         checksum <= '0;
      end else begin
         if (accept && state == S_HDR0) n_count[7:0]  <= in_data;
         if (accept && state == S_HDR1) n_count[15:8] <= in_data;
         if (load_byte)                 checksum      <= checksum ^ in_data;
         if (state == S_WRITE)          word_idx      <= word_idx_inc;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed byte streams, a posedge
// write monitor and immediate-assertion comparisons at each step.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        done;
   logic        error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   prog_loader #(.MAX_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Record every memory write as seen just before the clock edge.
   always @(posedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   // Absolute time bound so the run always ends.
   initial begin
      #300000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the byte is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("accept_wait", 64'(guard < 20), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   // Sends one LE word and checks the WRITE cycle that must follow at once.
   task automatic send_word(input logic [31:0] w, input int idx, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
      chk("write_we",    64'(imem_we),   64'd1);
      chk("write_addr",  imem_addr,      64'(idx * 4));
      chk("write_data",  64'(imem_wdata), 64'(w));
      chk("write_ready", 64'(in_ready),  64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);

      // Reset state, with in_valid high to show nothing is taken.
      in_valid = 1'b1;
      in_data  = 8'h5A;
      @(negedge clk);
      chk("rst_ready",      64'(in_ready),   64'd1);
      chk("rst_we",         64'(imem_we),    64'd0);
      chk("rst_addr",       imem_addr,       64'd0);
      chk("rst_wdata",      64'(imem_wdata), 64'd0);
      chk("rst_core_reset", 64'(core_reset), 64'd1);
      chk("rst_done",       64'(done),       64'd0);
      chk("rst_error",      64'(error),      64'd0);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);

      // One word 0x00A00513, checksum 13^05^A0^00 = B6.
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      chk("one_pre_ready", 64'(in_ready), 64'd1);
      send_word(32'h00A00513, 0, 0);
      send_byte(8'hB6, 0);
      chk("one_done",       64'(done),       64'd1);
      chk("one_core_reset", 64'(core_reset), 64'd0);
      chk("one_error",      64'(error),      64'd0);
      chk("one_ready",      64'(in_ready),   64'd0);
      chk("one_we_idle",    64'(imem_we),    64'd0);
      // Bytes offered in DONE are ignored.
      in_valid = 1'b1;
      in_data  = 8'h13;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("one_done_held", 64'(done),            64'd1);
      chk("one_wr_count",  64'(wr_addr_q.size()), 64'd1);
      chk("one_wr_addr",   wr_addr_q[0],         64'h0);
      chk("one_wr_data",   64'(wr_data_q[0]),    64'h00A00513);

      // Two words with a one-cycle gap before every byte.
      // Checksum 44^33^22^11^88^77^66^55 = 88.
      pulse_reset();
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      send_word(32'h11223344, 0, 1);
      send_word(32'h55667788, 1, 1);
      send_byte(8'h88, 1);
      chk("two_done",       64'(done),             64'd1);
      chk("two_core_reset", 64'(core_reset),       64'd0);
      chk("two_wr_count",   64'(wr_addr_q.size()), 64'd2);
      chk("two_wr_addr1",   wr_addr_q[1],          64'h4);
      chk("two_wr_data1",   64'(wr_data_q[1]),     64'h55667788);

      // Empty program: header 00 00, checksum 00.
      pulse_reset();
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("empty_done",     64'(done),             64'd1);
      chk("empty_wr_count", 64'(wr_addr_q.size()), 64'd0);

      // Bad checksum: word 0x00000013 sums to 13, FF supplied.
      pulse_reset();
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h00000013, 0, 0);
      send_byte(8'hFF, 0);
      chk("bad_error",      64'(error),      64'd1);
      chk("bad_core_reset", 64'(core_reset), 64'd1);
      chk("bad_done",       64'(done),       64'd0);
      chk("bad_ready",      64'(in_ready),   64'd0);

      // N = 256 is exactly the limit and is accepted into LOAD.
      pulse_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      chk("max_ready", 64'(in_ready), 64'd1);
      chk("max_error", 64'(error),    64'd0);

      // N = 257 exceeds the limit and goes straight to ERR.
      pulse_reset();
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("over_error", 64'(error),    64'd1);
      chk("over_ready", 64'(in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("over_wr_count", 64'(wr_addr_q.size()), 64'd0);

      // Reset after two bytes of a word, then a complete stream.
      pulse_reset();
      wr_addr_q.delete(); wr_data_q.delete();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      pulse_reset();
      chk("mid_rst_core_reset", 64'(core_reset), 64'd1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h00A00513, 0, 0);
      send_byte(8'hB6, 0);
      chk("mid_done",     64'(done),             64'd1);
      chk("mid_wr_count", 64'(wr_addr_q.size()), 64'd1);
      chk("mid_wr_addr",  wr_addr_q[0],          64'h0);
      chk("mid_wr_data",  64'(wr_data_q[0]),     64'h00A00513);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
